// File: rtl/alu_regfile_pipe_if.sv
// rtl/alu_regfile_pipe_if.sv - instruction/result interface for alu_regfile_pipe
// Purpose: groups the instruction handshake and the result pulse of the core.
// Signals:
//   in_valid/in_ready       instruction handshake (master -> core)
//   in_op, in_rs1, in_rs2   ALU function and source registers
//   in_rd, in_we            destination register and write enable
//   res_valid               one-cycle result pulse (core -> master)
//   res_data/zero/carry     result value and flags
// Modports: master (instruction source / result sink), slave (the core).
interface alu_regfile_pipe_if #(
  parameter int DATA_W = 8,
  parameter int NREGS  = 8
);
  localparam int RA_W = $clog2(NREGS);

  logic              in_valid;
  logic              in_ready;
  logic [3:0]        in_op;
  logic [RA_W-1:0]   in_rs1;
  logic [RA_W-1:0]   in_rs2;
  logic [RA_W-1:0]   in_rd;
  logic              in_we;
  logic              res_valid;
  logic [DATA_W-1:0] res_data;
  logic              res_zero;
  logic              res_carry;

  modport master (
    output in_valid, in_op, in_rs1, in_rs2, in_rd, in_we,
    input  in_ready, res_valid, res_data, res_zero, res_carry
  );

  modport slave (
    input  in_valid, in_op, in_rs1, in_rs2, in_rd, in_we,
    output in_ready, res_valid, res_data, res_zero, res_carry
  );
endinterface

// File: rtl/alu_regfile_pipe.sv
// rtl/alu_regfile_pipe.sv - two-stage ALU/register-file core with forwarding and optional divider
// Purpose: READ stage latches register operands (with forwarding from EX) on
//   instruction accept; EXECUTE/WRITEBACK computes the result, writes reg[rd]
//   and registers a one-cycle res_valid pulse.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    alu_regfile_pipe_if.slave: in_valid/in_ready/in_op/in_rs1/in_rs2/
//          in_rd/in_we in, res_valid/res_data/res_zero/res_carry out
// Configuration macro: ALU_DIV_EN
//   defined   -> DIV/MOD run on a restoring divider (1 bit/cycle), in_ready
//                drops while it runs
//   undefined -> no divider; DIV/MOD return all ones in one cycle, in_ready = 1
module alu_regfile_pipe #(
  parameter int DATA_W = 8,
  parameter int NREGS  = 8,
  parameter int RA_W   = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst_n,
  alu_regfile_pipe_if.slave bus
);

  localparam logic [3:0] OP_AND  = 4'd0;
  localparam logic [3:0] OP_OR   = 4'd1;
  localparam logic [3:0] OP_XOR  = 4'd2;
  localparam logic [3:0] OP_NAND = 4'd3;
  localparam logic [3:0] OP_NOR  = 4'd4;
  localparam logic [3:0] OP_XNOR = 4'd5;
  localparam logic [3:0] OP_ADD  = 4'd6;
  localparam logic [3:0] OP_SUB  = 4'd7;
  localparam logic [3:0] OP_MUL  = 4'd8;
  localparam logic [3:0] OP_DIV  = 4'd9;
  localparam logic [3:0] OP_MOD  = 4'd10;
  localparam logic [3:0] OP_LT   = 4'd11;
  localparam logic [3:0] OP_GT   = 4'd12;
  localparam logic [3:0] OP_EQ   = 4'd13;
  localparam logic [3:0] OP_SHL  = 4'd14;

  localparam logic [DATA_W-1:0] SH_LIMIT = DATA_W'(DATA_W);

  logic [DATA_W-1:0] rf_q [NREGS];

  logic              ex_valid_q;
  logic [3:0]        ex_op_q;
  logic [DATA_W-1:0] ex_a_q;
  logic [DATA_W-1:0] ex_b_q;
  logic [RA_W-1:0]   ex_rd_q;
  logic              ex_we_q;

  logic              res_valid_q;
  logic [DATA_W-1:0] res_data_q;
  logic              res_zero_q;
  logic              res_carry_q;

  logic              in_ready_w;
  logic              accept;
  logic              div_start;
  logic              wb_valid;
  logic [DATA_W-1:0] wb_data;
  logic              wb_carry;
  logic              fwd_en;
  logic [DATA_W-1:0] op_a_d;
  logic [DATA_W-1:0] op_b_d;

  // ---------------- execute: single-cycle ALU ----------------
  logic [DATA_W:0]     add_full;
  logic [DATA_W:0]     sub_full;
  logic [2*DATA_W-1:0] mul_full;
  logic                sh_ok;
  logic [DATA_W-1:0]   alu_res;
  logic                alu_carry;

  assign add_full = {1'b0, ex_a_q} + {1'b0, ex_b_q};
  // MSB of the widened difference is the borrow.
  assign sub_full = {1'b0, ex_a_q} - {1'b0, ex_b_q};
  assign mul_full = {{DATA_W{1'b0}}, ex_a_q} * {{DATA_W{1'b0}}, ex_b_q};
  assign sh_ok    = ex_b_q < SH_LIMIT;

  always_comb begin
    alu_res   = '0;
    alu_carry = 1'b0;
    case (ex_op_q)
      OP_AND:  alu_res = ex_a_q & ex_b_q;
      OP_OR:   alu_res = ex_a_q | ex_b_q;
      OP_XOR:  alu_res = ex_a_q ^ ex_b_q;
      OP_NAND: alu_res = ~(ex_a_q & ex_b_q);
      OP_NOR:  alu_res = ~(ex_a_q | ex_b_q);
      OP_XNOR: alu_res = ~(ex_a_q ^ ex_b_q);
      OP_ADD: begin
        alu_res   = add_full[DATA_W-1:0];
        alu_carry = add_full[DATA_W];
      end
      OP_SUB: begin
        alu_res   = sub_full[DATA_W-1:0];
        alu_carry = sub_full[DATA_W];
      end
      OP_MUL: begin
        alu_res   = mul_full[DATA_W-1:0];
        alu_carry = |mul_full[2*DATA_W-1:DATA_W];
      end
      // With the divider present these only reach EX for a zero divisor.
      OP_DIV:  alu_res = '1;
`ifdef ALU_DIV_EN
      OP_MOD:  alu_res = ex_a_q;
`else
      OP_MOD:  alu_res = '1;
`endif
      OP_LT:   alu_res = DATA_W'(ex_a_q < ex_b_q);
      OP_GT:   alu_res = DATA_W'(ex_a_q > ex_b_q);
      OP_EQ:   alu_res = DATA_W'(ex_a_q == ex_b_q);
      OP_SHL:  alu_res = sh_ok ? (ex_a_q << ex_b_q) : '0;
      default: alu_res = sh_ok ? (ex_a_q >> ex_b_q) : '0;
    endcase
  end

`ifdef ALU_DIV_EN
  // ---------------- iterative restoring divider ----------------
  localparam int CNT_W = (DATA_W > 2) ? $clog2(DATA_W) : 1;

  typedef enum logic [1:0] {S_IDLE, S_DIV_RUN, S_DONE} div_state_e;

  div_state_e        state_q;
  logic              ready_q;
  logic [DATA_W-1:0] quo_q;
  logic [DATA_W-1:0] rem_q;
  logic [DATA_W-1:0] dvs_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [DATA_W:0]   rem_shift;
  logic              rem_ge;
  logic [DATA_W-1:0] rem_sub;

  // quo_q starts as the dividend and is shifted out MSB-first while quotient
  // bits are shifted in at the bottom.
  assign rem_shift = {rem_q, quo_q[DATA_W-1]};
  assign rem_ge    = rem_shift >= {1'b0, dvs_q};
  // True difference is below dvs_q, so the low bits are exact.
  assign rem_sub   = rem_shift[DATA_W-1:0] - dvs_q;

  assign div_start  = accept && (bus.in_op == OP_DIV || bus.in_op == OP_MOD) && (op_b_d != '0);
  assign in_ready_w = ready_q;
  assign wb_valid   = ex_valid_q || (state_q == S_DONE);
  assign wb_data    = ex_valid_q ? alu_res : ((ex_op_q == OP_MOD) ? rem_q : quo_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ready_q <= 1'b1;
      quo_q   <= '0;
      rem_q   <= '0;
      dvs_q   <= '0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (div_start) begin
            state_q <= S_DIV_RUN;
            ready_q <= 1'b0;
            quo_q   <= op_a_d;
            rem_q   <= '0;
            dvs_q   <= op_b_d;
            cnt_q   <= CNT_W'(DATA_W - 1);
          end
        end
        S_DIV_RUN: begin
          if (rem_ge) begin
            rem_q <= rem_sub;
            quo_q <= {quo_q[DATA_W-2:0], 1'b1};
          end else begin
            rem_q <= rem_shift[DATA_W-1:0];
            quo_q <= {quo_q[DATA_W-2:0], 1'b0};
          end
          if (cnt_q == '0) begin
            state_q <= S_DONE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          ready_q <= 1'b1;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end
`else
  assign div_start  = 1'b0;
  assign in_ready_w = 1'b1;
  assign wb_valid   = ex_valid_q;
  assign wb_data    = alu_res;
`endif

  assign wb_carry = ex_valid_q && alu_carry;

  // ---------------- read stage with forwarding ----------------
  assign accept = bus.in_valid && in_ready_w;
  assign fwd_en = wb_valid && ex_we_q;
  assign op_a_d = (fwd_en && (ex_rd_q == bus.in_rs1)) ? wb_data : rf_q[bus.in_rs1];
  assign op_b_d = (fwd_en && (ex_rd_q == bus.in_rs2)) ? wb_data : rf_q[bus.in_rs2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        rf_q[i] <= DATA_W'(i);
      end
      ex_valid_q  <= 1'b0;
      ex_op_q     <= '0;
      ex_a_q      <= '0;
      ex_b_q      <= '0;
      ex_rd_q     <= '0;
      ex_we_q     <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_zero_q  <= 1'b0;
      res_carry_q <= 1'b0;
    end else begin
      if (wb_valid && ex_we_q) begin
        rf_q[ex_rd_q] <= wb_data;
      end
      res_valid_q <= wb_valid;
      if (wb_valid) begin
        res_data_q  <= wb_data;
        res_zero_q  <= (wb_data == '0);
        res_carry_q <= wb_carry;
      end
      // A started divide keeps the EX slot but completes through the FSM.
      ex_valid_q <= accept && !div_start;
      if (accept) begin
        ex_op_q <= bus.in_op;
        ex_a_q  <= op_a_d;
        ex_b_q  <= op_b_d;
        ex_rd_q <= bus.in_rd;
        ex_we_q <= bus.in_we;
      end
    end
  end

  assign bus.in_ready  = in_ready_w;
  assign bus.res_valid = res_valid_q;
  assign bus.res_data  = res_data_q;
  assign bus.res_zero  = res_zero_q;
  assign bus.res_carry = res_carry_q;

endmodule

// File: tb/tb_alu_regfile_pipe.sv
// tb/tb_alu_regfile_pipe.sv - directed self-checking bench for alu_regfile_pipe
module tb_alu_regfile_pipe;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   passed = 0;

  alu_regfile_pipe_if #(.DATA_W(8), .NREGS(8)) bus ();

  alu_regfile_pipe #(.DATA_W(8), .NREGS(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  task automatic drive(input logic [3:0] op, input logic [2:0] rs1, input logic [2:0] rs2,
                       input logic [2:0] rd, input logic we);
    bus.in_valid = 1'b1;
    bus.in_op    = op;
    bus.in_rs1   = rs1;
    bus.in_rs2   = rs2;
    bus.in_rd    = rd;
    bus.in_we    = we;
  endtask

  task automatic do_reset();
    bus.in_valid = 1'b0;
    bus.in_op    = 4'd0;
    bus.in_rs1   = 3'd0;
    bus.in_rs2   = 3'd0;
    bus.in_rd    = 3'd0;
    bus.in_we    = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Issue one instruction, wait (bounded) for its result pulse.
  // lat counts edges from the accept edge inclusive; rdy_low counts
  // post-accept cycles with in_ready low.
  task automatic exec(input logic [3:0] op, input logic [2:0] rs1, input logic [2:0] rs2,
                      input logic [2:0] rd, input logic we,
                      output logic [7:0] d, output logic z, output logic c,
                      output int lat, output int rdy_low);
    int guard;
    @(negedge clk);
    drive(op, rs1, rs2, rd, we);
    guard = 0;
    while (!bus.in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    @(posedge clk);
    lat = 1;
    rdy_low = 0;
    @(negedge clk);
    bus.in_valid = 1'b0;
    while (!bus.res_valid && lat < 40) begin
      if (!bus.in_ready) rdy_low++;
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    d = bus.res_data;
    z = bus.res_zero;
    c = bus.res_carry;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (bus.in_ready !== 1'b1) $display("FAIL reset_in_ready got %0b want 1", bus.in_ready); else passed++;
    checks++; if (bus.res_valid !== 1'b0) $display("FAIL reset_res_valid got %0b want 0", bus.res_valid); else passed++;
    checks++; if (bus.res_data !== 8'd0) $display("FAIL reset_res_data got %0d want 0", bus.res_data); else passed++;
    checks++; if (bus.res_zero !== 1'b0) $display("FAIL reset_res_zero got %0b want 0", bus.res_zero); else passed++;
    checks++; if (bus.res_carry !== 1'b0) $display("FAIL reset_res_carry got %0b want 0", bus.res_carry); else passed++;
  endtask

  task automatic test_add();
    logic [7:0] d; logic z, c; int lat, rl;
    do_reset();
    exec(4'd6, 3'd3, 3'd5, 3'd1, 1'b1, d, z, c, lat, rl);
    checks++; if (d !== 8'd8) $display("FAIL add_data got %0d want 8", d); else passed++;
    checks++; if (z !== 1'b0 || c !== 1'b0) $display("FAIL add_flags got z=%0b c=%0b want z=0 c=0", z, c); else passed++;
    checks++; if (lat != 2) $display("FAIL add_latency got %0d want 2", lat); else passed++;
    @(negedge clk);
    checks++; if (bus.res_valid !== 1'b0) $display("FAIL add_pulse_width got %0b want 0", bus.res_valid); else passed++;
    exec(4'd1, 3'd1, 3'd1, 3'd0, 1'b0, d, z, c, lat, rl);
    checks++; if (d !== 8'd8) $display("FAIL add_readback_r1 got %0d want 8", d); else passed++;
  endtask

  task automatic test_back_to_back();
    do_reset();
    @(negedge clk);
    drive(4'd6, 3'd3, 3'd5, 3'd1, 1'b1);
    @(posedge clk);
    @(negedge clk);
    drive(4'd7, 3'd1, 3'd3, 3'd2, 1'b1);
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    checks++; if (bus.res_valid !== 1'b1 || bus.res_data !== 8'd8) $display("FAIL b2b_first got v=%0b d=%0d want v=1 d=8", bus.res_valid, bus.res_data); else passed++;
    @(negedge clk);
    checks++; if (bus.res_valid !== 1'b1 || bus.res_data !== 8'd5) $display("FAIL b2b_second_fwd got v=%0b d=%0d want v=1 d=5", bus.res_valid, bus.res_data); else passed++;
    checks++; if (bus.res_carry !== 1'b0) $display("FAIL b2b_second_borrow got %0b want 0", bus.res_carry); else passed++;
    @(negedge clk);
    checks++; if (bus.res_valid !== 1'b0) $display("FAIL b2b_idle got %0b want 0", bus.res_valid); else passed++;
  endtask

  task automatic test_mul();
    logic [7:0] d; logic z, c; int lat, rl;
    do_reset();
    exec(4'd8, 3'd7, 3'd6, 3'd0, 1'b0, d, z, c, lat, rl);
    checks++; if (d !== 8'd42 || c !== 1'b0) $display("FAIL mul_42 got d=%0d c=%0b want d=42 c=0", d, c); else passed++;
    exec(4'd8, 3'd5, 3'd5, 3'd1, 1'b1, d, z, c, lat, rl);   // r1 = 25
    exec(4'd6, 3'd3, 3'd5, 3'd3, 1'b1, d, z, c, lat, rl);   // r3 = 8
    exec(4'd8, 3'd1, 3'd3, 3'd1, 1'b1, d, z, c, lat, rl);   // r1 = 200
    checks++; if (d !== 8'd200 || c !== 1'b0) $display("FAIL mul_load200 got d=%0d c=%0b want d=200 c=0", d, c); else passed++;
    exec(4'd8, 3'd1, 3'd2, 3'd0, 1'b0, d, z, c, lat, rl);
    checks++; if (d !== 8'd144) $display("FAIL mul_wrap_data got %0d want 144", d); else passed++;
    checks++; if (c !== 1'b1) $display("FAIL mul_wrap_carry got %0b want 1", c); else passed++;
  endtask

  task automatic test_ops();
    logic [3:0] ops [8]  = '{4'd0, 4'd2, 4'd4, 4'd7, 4'd12, 4'd13, 4'd11, 4'd14};
    logic [2:0] s1s [8]  = '{3'd7, 3'd6, 3'd5, 3'd3, 3'd7, 3'd4, 3'd5, 3'd1};
    logic [2:0] s2s [8]  = '{3'd5, 3'd3, 3'd2, 3'd5, 3'd1, 3'd4, 3'd4, 3'd7};
    logic [7:0] exd [8]  = '{8'd5, 8'd5, 8'hF8, 8'hFE, 8'd1, 8'd1, 8'd0, 8'h80};
    logic       exz [8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic       exc [8]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [7:0] d; logic z, c; int lat, rl;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      exec(ops[i], s1s[i], s2s[i], 3'd0, 1'b0, d, z, c, lat, rl);
      checks++;
      if (d !== exd[i] || z !== exz[i] || c !== exc[i])
        $display("FAIL op%0d got d=%0h z=%0b c=%0b want d=%0h z=%0b c=%0b", ops[i], d, z, c, exd[i], exz[i], exc[i]);
      else passed++;
    end
    exec(4'd6, 3'd4, 3'd5, 3'd6, 1'b1, d, z, c, lat, rl);   // r6 = 9
    exec(4'd15, 3'd7, 3'd6, 3'd0, 1'b0, d, z, c, lat, rl);
    checks++; if (d !== 8'd0 || z !== 1'b1) $display("FAIL shr_over_width got d=%0d z=%0b want d=0 z=1", d, z); else passed++;
  endtask

  task automatic test_we0();
    logic [7:0] d; logic z, c; int lat, rl;
    do_reset();
    exec(4'd6, 3'd2, 3'd3, 3'd1, 1'b0, d, z, c, lat, rl);
    checks++; if (d !== 8'd5) $display("FAIL we0_result got %0d want 5", d); else passed++;
    exec(4'd1, 3'd1, 3'd1, 3'd0, 1'b0, d, z, c, lat, rl);
    checks++; if (d !== 8'd1) $display("FAIL we0_r1_unchanged got %0d want 1", d); else passed++;
  endtask

`ifdef ALU_DIV_EN
  task automatic test_div();
    logic [7:0] d; logic z, c; int lat, rl;
    do_reset();
    exec(4'd9, 3'd7, 3'd2, 3'd1, 1'b1, d, z, c, lat, rl);
    checks++; if (d !== 8'd3 || c !== 1'b0) $display("FAIL div_data got d=%0d c=%0b want d=3 c=0", d, c); else passed++;
    checks++; if (lat != 10) $display("FAIL div_latency got %0d want 10", lat); else passed++;
    checks++; if (rl != 9) $display("FAIL div_ready_low got %0d want 9", rl); else passed++;
    exec(4'd10, 3'd7, 3'd2, 3'd0, 1'b0, d, z, c, lat, rl);
    checks++; if (d !== 8'd1) $display("FAIL mod_data got %0d want 1", d); else passed++;
    exec(4'd9, 3'd7, 3'd0, 3'd0, 1'b0, d, z, c, lat, rl);
    checks++; if (d !== 8'hFF || c !== 1'b0 || lat != 2) $display("FAIL div_by_zero got d=%0h c=%0b lat=%0d want d=ff c=0 lat=2", d, c, lat); else passed++;
    exec(4'd10, 3'd7, 3'd0, 3'd0, 1'b0, d, z, c, lat, rl);
    checks++; if (d !== 8'd7 || lat != 2) $display("FAIL mod_by_zero got d=%0d lat=%0d want d=7 lat=2", d, lat); else passed++;
    exec(4'd1, 3'd1, 3'd1, 3'd0, 1'b0, d, z, c, lat, rl);
    checks++; if (d !== 8'd3) $display("FAIL div_writeback_r1 got %0d want 3", d); else passed++;
  endtask

  task automatic test_hold();
    logic [7:0] d1; logic div_seen, div_before_acc, accepted;
    int n;
    do_reset();
    @(negedge clk);
    drive(4'd9, 3'd7, 3'd2, 3'd1, 1'b1);
    @(posedge clk);
    @(negedge clk);
    drive(4'd0, 3'd7, 3'd6, 3'd0, 1'b0);
    div_seen = 1'b0; div_before_acc = 1'b0; accepted = 1'b0; d1 = 8'd0; n = 0;
    while (!accepted && n < 40) begin
      if (bus.res_valid && !div_seen) begin
        div_seen = 1'b1;
        d1 = bus.res_data;
      end
      if (bus.in_ready) begin
        accepted = 1'b1;
        div_before_acc = div_seen;
      end
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    bus.in_valid = 1'b0;
    checks++; if (d1 !== 8'd3) $display("FAIL hold_div_data got %0d want 3", d1); else passed++;
    checks++; if (div_before_acc !== 1'b1) $display("FAIL hold_order got %0b want 1", div_before_acc); else passed++;
    checks++; if (bus.res_valid !== 1'b0) $display("FAIL hold_gap got %0b want 0", bus.res_valid); else passed++;
    @(negedge clk);
    checks++; if (bus.res_valid !== 1'b1 || bus.res_data !== 8'd6) $display("FAIL hold_and got v=%0b d=%0d want v=1 d=6", bus.res_valid, bus.res_data); else passed++;
  endtask

  task automatic test_reset_mid_div();
    logic [7:0] d; logic z, c; int lat, rl;
    logic seen;
    do_reset();
    exec(4'd6, 3'd3, 3'd5, 3'd1, 1'b1, d, z, c, lat, rl);
    @(negedge clk);
    drive(4'd9, 3'd7, 3'd2, 3'd1, 1'b1);
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    checks++; if (bus.res_valid !== 1'b0) $display("FAIL middiv_async got %0b want 0", bus.res_valid); else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (bus.res_valid) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) $display("FAIL middiv_no_result got %0b want 0", seen); else passed++;
    exec(4'd1, 3'd1, 3'd1, 3'd0, 1'b0, d, z, c, lat, rl);
    checks++; if (d !== 8'd1) $display("FAIL middiv_r1_reset got %0d want 1", d); else passed++;
  endtask
`else
  task automatic test_div_disabled();
    logic [7:0] d; logic z, c; int lat, rl;
    do_reset();
    exec(4'd9, 3'd7, 3'd2, 3'd0, 1'b0, d, z, c, lat, rl);
    checks++; if (d !== 8'hFF || c !== 1'b0) $display("FAIL nodiv_div got d=%0h c=%0b want d=ff c=0", d, c); else passed++;
    checks++; if (lat != 2 || rl != 0) $display("FAIL nodiv_timing got lat=%0d rdy_low=%0d want lat=2 rdy_low=0", lat, rl); else passed++;
    exec(4'd10, 3'd7, 3'd2, 3'd0, 1'b0, d, z, c, lat, rl);
    checks++; if (d !== 8'hFF) $display("FAIL nodiv_mod got %0h want ff", d); else passed++;
  endtask
`endif

  initial begin
    test_reset();
    test_add();
    test_back_to_back();
    test_mul();
    test_ops();
    test_we0();
`ifdef ALU_DIV_EN
    test_div();
    test_hold();
    test_reset_mid_div();
`else
    test_div_disabled();
`endif
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
